// File: rtl/ifu_iccm_dma_arb_if.sv
// ifu_iccm_dma_arb_if: DMA request/response and ICCM port bundle for the ICCM DMA arbiter
//   slave  : arbiter view (takes DMA request, fetch status, ICCM read data; drives ready, ICCM strobes, responses, stall)
//   master : environment view (DMA slave, fetch control and ICCM model)
interface ifu_iccm_dma_arb_if;
    logic        dma_access_ok;
    logic        dma_req_valid;
    logic        dma_req_ready;
    logic        dma_req_write;
    logic [31:0] dma_req_addr;
    logic [63:0] dma_req_wdata;
    logic        iccm_dma_rden;
    logic        iccm_dma_wren;
    logic [31:0] iccm_dma_addr;
    logic [63:0] iccm_dma_wdata;
    logic [63:0] iccm_rd_data;
    logic        dma_rsp_valid;
    logic [63:0] dma_rsp_data;
    logic        dma_rsp_err;
    logic        dma_wr_err;
    logic        dma_iccm_stall_any;
    modport slave (
        input  dma_access_ok, dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata, iccm_rd_data,
        output dma_req_ready, iccm_dma_rden, iccm_dma_wren, iccm_dma_addr, iccm_dma_wdata,
               dma_rsp_valid, dma_rsp_data, dma_rsp_err, dma_wr_err, dma_iccm_stall_any
    );
    modport master (
        output dma_access_ok, dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata, iccm_rd_data,
        input  dma_req_ready, iccm_dma_rden, iccm_dma_wren, iccm_dma_addr, iccm_dma_wdata,
               dma_rsp_valid, dma_rsp_data, dma_rsp_err, dma_wr_err, dma_iccm_stall_any
    );
endinterface

// File: rtl/ifu_iccm_dma_arb.sv
// ifu_iccm_dma_arb: shares the ICCM port between fetch and DMA, with starvation-driven fetch stall
//   clk : core clock
//   rst : synchronous active-high reset
//   bus : ifu_iccm_dma_arb_if.slave (DMA request/response, ICCM strobes, fetch status and stall)
module ifu_iccm_dma_arb #(
    parameter int unsigned STARVE_MAX = 15,
    parameter logic [31:0] ICCM_SADR  = 32'hEE00_0000,
    parameter logic [31:0] ICCM_SIZE  = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_iccm_dma_arb_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RDWAIT, ERRWAIT} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rsp_valid_q, rsp_err_q, wr_err_q, stall_q;
    logic [63:0] rsp_data_q;
    logic        in_range, ready, accept, blocked;
    always_comb begin
        in_range = (bus.dma_req_addr & ~(ICCM_SIZE - 32'd1)) == ICCM_SADR;
        // out-of-range requests never reach the ICCM, so they need no fetch permission
        ready    = ~rst & (state_q == IDLE) & (bus.dma_access_ok | ~in_range);
        accept   = bus.dma_req_valid & ready;
        blocked  = (state_q == IDLE) & bus.dma_req_valid & ~ready;
    end
    assign bus.dma_req_ready      = ready;
    assign bus.iccm_dma_rden      = accept & ~bus.dma_req_write & in_range;
    assign bus.iccm_dma_wren      = accept & bus.dma_req_write & in_range;
    assign bus.iccm_dma_addr      = bus.dma_req_addr;
    assign bus.iccm_dma_wdata     = bus.dma_req_wdata;
    assign bus.dma_rsp_valid      = rsp_valid_q;
    assign bus.dma_rsp_data       = rsp_data_q;
    assign bus.dma_rsp_err        = rsp_err_q;
    assign bus.dma_wr_err         = wr_err_q;
    assign bus.dma_iccm_stall_any = stall_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 64'd0;
            wr_err_q    <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= (state_q != IDLE) ? IDLE :
                           (accept & ~bus.dma_req_write) ? (in_range ? RDWAIT : ERRWAIT) : IDLE;
            rsp_valid_q <= state_q != IDLE;
            rsp_err_q   <= state_q == ERRWAIT;
            rsp_data_q  <= (state_q == RDWAIT) ? bus.iccm_rd_data :
                           (state_q == ERRWAIT) ? 64'd0 : rsp_data_q;
            wr_err_q    <= accept & bus.dma_req_write & ~in_range;
            cnt_q       <= (accept | ~bus.dma_req_valid) ? 4'd0 :
                           (blocked & (cnt_q != 4'(STARVE_MAX))) ? cnt_q + 4'd1 : cnt_q;
            // stall is sticky until the waiting request is granted or withdrawn
            stall_q     <= (accept | ~bus.dma_req_valid) ? 1'b0 :
                           stall_q | (blocked & (cnt_q == 4'(STARVE_MAX)));
        end
    end
endmodule

// File: tb/tb_ifu_iccm_dma_arb.sv
// tb_ifu_iccm_dma_arb: directed self-checking bench for ifu_iccm_dma_arb
module tb_ifu_iccm_dma_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ifu_iccm_dma_arb_if bus();
    ifu_iccm_dma_arb dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the edge, checks happen 1 more unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.dma_access_ok = 1'b1;
        bus.dma_req_valid = 1'b1;
        bus.dma_req_write = 1'b0;
        bus.dma_req_addr  = 32'hEE00_0000;
        bus.dma_req_wdata = 64'd0;
        bus.iccm_rd_data  = 64'd0;
        tick();
        tick();
        settle();
        chk("rst_ready", bus.dma_req_ready, 0);
        chk("rst_rden", bus.iccm_dma_rden, 0);
        chk("rst_rsp_valid", bus.dma_rsp_valid, 0);
        chk("rst_rsp_data", bus.dma_rsp_data, 0);
        chk("rst_rsp_err", bus.dma_rsp_err, 0);
        chk("rst_wr_err", bus.dma_wr_err, 0);
        chk("rst_stall", bus.dma_iccm_stall_any, 0);
        bus.dma_req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // in-range read
        tick();
        bus.dma_req_valid = 1'b1;
        bus.dma_req_addr  = 32'hEE00_0008;
        settle();
        chk("rd_ready", bus.dma_req_ready, 1);
        chk("rd_rden", bus.iccm_dma_rden, 1);
        chk("rd_wren", bus.iccm_dma_wren, 0);
        chk("rd_addr", bus.iccm_dma_addr, 64'hEE00_0008);
        tick();
        bus.dma_req_valid = 1'b0;
        bus.iccm_rd_data  = 64'hDEAD_BEEF_0123_4567;
        settle();
        chk("rd_busy_ready", bus.dma_req_ready, 0);
        chk("rd_t1_valid", bus.dma_rsp_valid, 0);
        tick();
        bus.iccm_rd_data = 64'h0;
        settle();
        chk("rd_t2_valid", bus.dma_rsp_valid, 1);
        chk("rd_t2_data", bus.dma_rsp_data, 64'hDEAD_BEEF_0123_4567);
        chk("rd_t2_err", bus.dma_rsp_err, 0);
        tick();
        settle();
        chk("rd_t3_valid", bus.dma_rsp_valid, 0);
        chk("rd_t3_hold", bus.dma_rsp_data, 64'hDEAD_BEEF_0123_4567);

        // four back-to-back writes
        bus.dma_req_valid = 1'b1;
        bus.dma_req_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.dma_req_addr  = 32'hEE00_0010 + 32'(8 * i);
            bus.dma_req_wdata = 64'h1111_0000_0000_0000 + 64'(i);
            settle();
            chk("wr_ready", bus.dma_req_ready, 1);
            chk("wr_wren", bus.iccm_dma_wren, 1);
            chk("wr_wdata", bus.iccm_dma_wdata, 64'h1111_0000_0000_0000 + 64'(i));
            chk("wr_rsp", bus.dma_rsp_valid, 0);
            tick();
        end
        bus.dma_req_valid = 1'b0;
        settle();
        chk("wr_after_rsp", bus.dma_rsp_valid, 0);
        chk("wr_after_err", bus.dma_wr_err, 0);

        // out-of-range read with fetch busy
        tick();
        bus.dma_access_ok = 1'b0;
        bus.dma_req_valid = 1'b1;
        bus.dma_req_write = 1'b0;
        bus.dma_req_addr  = 32'h2000_0000;
        settle();
        chk("oor_rd_ready", bus.dma_req_ready, 1);
        chk("oor_rd_rden", bus.iccm_dma_rden, 0);
        tick();
        bus.dma_req_valid = 1'b0;
        settle();
        chk("oor_rd_t1", bus.dma_rsp_valid, 0);
        tick();
        settle();
        chk("oor_rd_valid", bus.dma_rsp_valid, 1);
        chk("oor_rd_err", bus.dma_rsp_err, 1);
        chk("oor_rd_data", bus.dma_rsp_data, 0);
        // out-of-range write
        bus.dma_req_valid = 1'b1;
        bus.dma_req_write = 1'b1;
        settle();
        chk("oor_wr_ready", bus.dma_req_ready, 1);
        chk("oor_wr_wren", bus.iccm_dma_wren, 0);
        tick();
        bus.dma_req_valid = 1'b0;
        settle();
        chk("oor_wr_err", bus.dma_wr_err, 1);
        chk("oor_wr_norsp", bus.dma_rsp_valid, 0);
        tick();
        settle();
        chk("oor_wr_err_pulse", bus.dma_wr_err, 0);

        // starvation: blocked read from T, stall at T+16, grant at T+17
        bus.dma_req_valid = 1'b1;
        bus.dma_req_write = 1'b0;
        bus.dma_req_addr  = 32'hEE00_0100;
        for (int k = 0; k <= 16; k++) begin
            settle();
            chk($sformatf("starve_stall_%0d", k), bus.dma_iccm_stall_any, (k >= 16) ? 64'd1 : 64'd0);
            chk($sformatf("starve_ready_%0d", k), bus.dma_req_ready, 0);
            tick();
        end
        bus.dma_access_ok = 1'b1;
        settle();
        chk("starve_t17_stall", bus.dma_iccm_stall_any, 1);
        chk("starve_t17_ready", bus.dma_req_ready, 1);
        chk("starve_t17_rden", bus.iccm_dma_rden, 1);
        tick();
        bus.dma_req_valid = 1'b0;
        settle();
        chk("starve_t18_stall", bus.dma_iccm_stall_any, 0);
        tick();
        tick();

        // withdrawal at T+5 clears the counter; a fresh request needs the full 16 cycles
        bus.dma_access_ok = 1'b0;
        bus.dma_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.dma_req_valid = 1'b0;
        tick();
        bus.dma_req_valid = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            settle();
            chk($sformatf("wd_stall_%0d", k), bus.dma_iccm_stall_any, (k >= 16) ? 64'd1 : 64'd0);
            tick();
        end
        bus.dma_req_valid = 1'b0;
        settle();
        chk("wd_drop_hold", bus.dma_iccm_stall_any, 1);
        tick();
        settle();
        chk("wd_drop_clear", bus.dma_iccm_stall_any, 0);

        // reset during RDWAIT discards the read
        bus.dma_access_ok = 1'b1;
        bus.dma_req_valid = 1'b1;
        bus.dma_req_addr  = 32'hEE00_0200;
        settle();
        chk("rr_accept", bus.iccm_dma_rden, 1);
        tick();
        bus.dma_req_valid = 1'b0;
        bus.iccm_rd_data  = 64'hCAFE_F00D_0000_0001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rr_valid", bus.dma_rsp_valid, 0);
        chk("rr_data", bus.dma_rsp_data, 0);
        chk("rr_err", bus.dma_rsp_err, 0);
        chk("rr_stall", bus.dma_iccm_stall_any, 0);
        tick();
        settle();
        chk("rr_valid2", bus.dma_rsp_valid, 0);
        bus.dma_req_valid = 1'b1;
        bus.dma_req_addr  = 32'hEE00_0208;
        settle();
        chk("rr_next_ready", bus.dma_req_ready, 1);
        chk("rr_next_rden", bus.iccm_dma_rden, 1);
        tick();
        bus.dma_req_valid = 1'b0;
        bus.iccm_rd_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        settle();
        chk("rr_next_valid", bus.dma_rsp_valid, 1);
        chk("rr_next_data", bus.dma_rsp_data, 64'h0123_4567_89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
